// File: rtl/debug_run_controller_if.sv
// Host-command / pipeline-control / dump-handshake bundle of the debug run controller.
// master = the controller, slave = the UART, pipeline and dump-sequencer side.
interface debug_run_controller_if;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        halt_detected;
  logic        dump_done;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_enable;
  logic        cpu_rst;
  logic        dump_start;
  logic        step_mode;
  logic        halted;
  logic        busy;
  logic        err;

  modport master (
    input  rx_done, rx_data, halt_detected, dump_done,
    output imem_we, imem_addr, imem_wdata, cpu_enable, cpu_rst,
           dump_start, step_mode, halted, busy, err
  );

  modport slave (
    output rx_done, rx_data, halt_detected, dump_done,
    input  imem_we, imem_addr, imem_wdata, cpu_enable, cpu_rst,
           dump_start, step_mode, halted, busy, err
  );
endinterface

// File: rtl/debug_run_controller.sv
// Host-driven MIPS run controller: program load over UART, run/step gating of the
// pipeline, and hand-off of the UART transmit path to the dump sequencer.
module debug_run_controller #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] HALT_WORD  = 32'h0000_0000,
  parameter logic [7:0]  CMD_LOAD   = 8'h4C,
  parameter logic [7:0]  CMD_RUN    = 8'h52,
  parameter logic [7:0]  CMD_STEP   = 8'h53
) (
  input  logic                  clk,
  input  logic                  rst,
  debug_run_controller_if.master bus
);

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned WORD_W    = 32;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_BYTE, LOAD_WRITE, RUN, STEP, DUMP_REQ, DUMP_WAIT
  } state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] word_next;

  // Bytes arrive MSB first.
  assign word_next = {word[WORD_W-9:0], bus.rx_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      byte_cnt       <= 2'd0;
      word           <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.cpu_enable <= 1'b0;
      bus.cpu_rst    <= 1'b0;
      bus.dump_start <= 1'b0;
      bus.step_mode  <= 1'b0;
      bus.halted     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.imem_we    <= 1'b0;
      bus.cpu_rst    <= 1'b0;
      bus.dump_start <= 1'b0;
      bus.cpu_enable <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.rx_done) begin
            if (bus.rx_data == CMD_LOAD) begin
              state         <= LOAD_BYTE;
              bus.busy      <= 1'b1;
              bus.imem_addr <= '0;
              byte_cnt      <= 2'd0;
              word          <= '0;
              bus.halted    <= 1'b0;
              bus.err       <= 1'b0;
            end else if (bus.rx_data == CMD_RUN && !bus.halted) begin
              state          <= RUN;
              bus.busy       <= 1'b1;
              bus.cpu_enable <= 1'b1;
              bus.step_mode  <= 1'b0;
            end else if (bus.rx_data == CMD_STEP && !bus.halted) begin
              state          <= STEP;
              bus.busy       <= 1'b1;
              bus.cpu_enable <= 1'b1;
              bus.step_mode  <= 1'b1;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end

        // The write strobe and the load-terminating cpu_rst are issued together.
        LOAD_BYTE: begin
          if (bus.rx_done) begin
            word     <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state          <= LOAD_WRITE;
              bus.imem_we    <= 1'b1;
              bus.imem_wdata <= word_next;
              if (word_next == HALT_WORD || bus.imem_addr == LAST_ADDR)
                bus.cpu_rst <= 1'b1;
            end
          end
        end

        LOAD_WRITE: begin
          if (word == HALT_WORD) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (bus.imem_addr == LAST_ADDR) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.err  <= 1'b1;
          end else begin
            bus.imem_addr <= bus.imem_addr + ADDR_W'(1);
            state         <= LOAD_BYTE;
          end
        end

        RUN: begin
          if (bus.halt_detected) begin
            bus.halted <= 1'b1;
            state      <= DUMP_REQ;
          end else begin
            bus.cpu_enable <= 1'b1;
          end
        end

        STEP: begin
          if (bus.halt_detected)
            bus.halted <= 1'b1;
          state <= DUMP_REQ;
        end

        DUMP_REQ: begin
          bus.dump_start <= 1'b1;
          state          <= DUMP_WAIT;
        end

        DUMP_WAIT: begin
          if (bus.dump_done) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_run_controller.sv
// Scoreboard bench for debug_run_controller: directed plan followed by random command mix.
module tb_debug_run_controller;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0] C_L = 8'h4C;
  localparam logic [7:0] C_R = 8'h52;
  localparam logic [7:0] C_S = 8'h53;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_run_controller_if dif();

  debug_run_controller #(
    .IMEM_DEPTH(DEPTH), .HALT_WORD(32'h0000_0000),
    .CMD_LOAD(C_L), .CMD_RUN(C_R), .CMD_STEP(C_S)
  ) dut (
    .clk(clk), .rst(rst), .bus(dif)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        cpu_rst;
  } wr_t;

  wr_t         wr_q[$];
  int          burst_start_q[$];
  int          burst_len_q[$];
  int          dump_q[$];
  logic [31:0] prog[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_rx_cyc;
  bit m_halted, m_err, m_step;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event, value %0h, nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, a dump request or an enable burst.
  int run_len = 0;
  int run_start = 0;
  always @(negedge clk) begin
    if (!rst) begin
      int active;
      active = int'(dif.imem_we) + int'(dif.cpu_enable) + int'(dif.dump_start);
      n_checks++;
      if (active > 1) begin
        n_fail++;
        $display("FAIL exclusive: we=%0b en=%0b ds=%0b all expected mutually exclusive",
                 dif.imem_we, dif.cpu_enable, dif.dump_start);
      end
      if (dif.imem_we) begin
        if (wr_q.size() == 0) unexpected("imem_we", dif.imem_addr);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          check("write addr", dif.imem_addr, e.addr);
          check("write data", dif.imem_wdata, e.data);
          check("write cpu_rst", 32'(dif.cpu_rst), 32'(e.cpu_rst));
        end
      end else if (dif.cpu_rst) begin
        unexpected("cpu_rst", 32'(dif.cpu_rst));
      end
      if (dif.dump_start) begin
        if (dump_q.size() == 0) unexpected("dump_start", 32'(cyc));
        else check("dump_start cycle", 32'(cyc), 32'(dump_q.pop_front()));
      end
      if (dif.cpu_enable) begin
        if (run_len == 0) run_start = cyc;
        run_len++;
      end else if (run_len > 0) begin
        if (burst_len_q.size() == 0) unexpected("cpu_enable burst", 32'(run_len));
        else begin
          check("burst start", 32'(run_start), 32'(burst_start_q.pop_front()));
          check("burst length", 32'(run_len), 32'(burst_len_q.pop_front()));
        end
        run_len = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    dif.rx_done = 1'b1;
    dif.rx_data = b;
    last_rx_cyc = cyc;
    tick();
    dif.rx_done = 1'b0;
  endtask

  function automatic logic [7:0] any_byte();
    logic [7:0] pick[4];
    pick[0] = C_L; pick[1] = C_R; pick[2] = C_S; pick[3] = 8'($urandom);
    return pick[$urandom_range(0, 3)];
  endfunction

  task automatic check_status(input string tag);
    repeat (2) tick();
    check({tag, " busy"},      32'(dif.busy),      32'(0));
    check({tag, " err"},       32'(dif.err),       32'(m_err));
    check({tag, " halted"},    32'(dif.halted),    32'(m_halted));
    check({tag, " step_mode"}, 32'(dif.step_mode), 32'(m_step));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " imem_we"},    32'(dif.imem_we),    32'(0));
    check({tag, " imem_addr"},  dif.imem_addr,       32'(0));
    check({tag, " imem_wdata"}, dif.imem_wdata,      32'(0));
    check({tag, " cpu_enable"}, 32'(dif.cpu_enable), 32'(0));
    check({tag, " cpu_rst"},    32'(dif.cpu_rst),    32'(0));
    check({tag, " dump_start"}, 32'(dif.dump_start), 32'(0));
    check({tag, " step_mode"},  32'(dif.step_mode),  32'(0));
    check({tag, " halted"},     32'(dif.halted),     32'(0));
    check({tag, " busy"},       32'(dif.busy),       32'(0));
    check({tag, " err"},        32'(dif.err),        32'(0));
  endtask

  // Program load: words up to the first halt word or the last address are written.
  task automatic do_load();
    send_byte(C_L);
    m_halted = 1'b0;
    m_err    = 1'b0;
    for (int i = 0; i < prog.size(); i++) begin
      bit last;
      last = (prog[i] == 32'h0) || (i == int'(DEPTH) - 1);
      wr_q.push_back('{addr: 32'(i), data: prog[i], cpu_rst: last});
      for (int b = 3; b >= 0; b--) send_byte(8'(prog[i] >> (8 * b)));
      if (last) begin
        m_err = (prog[i] != 32'h0);
        break;
      end
    end
  endtask

  task automatic dump_handshake(input int ndrop, input int delay);
    bit found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (dif.dump_start) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL dump_start timeout: got none within 40 cycles, expected one");
    end
    for (int d = 0; d < ndrop; d++) send_byte(any_byte());
    repeat (delay - 2 * ndrop - 1) tick();
    tick();
    dif.dump_done = 1'b1;
    tick();
    dif.dump_done = 1'b0;
  endtask

  task automatic do_run(input int n, input int ndrop, input int delay);
    int c0;
    send_byte(C_R);
    if (m_halted) begin
      m_err = 1'b1;
      return;
    end
    c0 = last_rx_cyc;
    m_step = 1'b0;
    burst_start_q.push_back(c0 + 1);
    burst_len_q.push_back(n);
    dump_q.push_back(c0 + n + 2);
    for (int k = 1; k < n; k++) begin
      dif.rx_done = (k == 1 && n >= 3);
      dif.rx_data = any_byte();
      tick();
    end
    dif.rx_done = 1'b0;
    dif.halt_detected = 1'b1;
    tick();
    dif.halt_detected = 1'b0;
    m_halted = 1'b1;
    dump_handshake(ndrop, delay);
  endtask

  task automatic do_step(input bit h, input int ndrop, input int delay);
    int c0;
    send_byte(C_S);
    if (m_halted) begin
      m_err = 1'b1;
      return;
    end
    c0 = last_rx_cyc;
    m_step = 1'b1;
    burst_start_q.push_back(c0 + 1);
    burst_len_q.push_back(1);
    dump_q.push_back(c0 + 3);
    dif.halt_detected = h;
    tick();
    dif.halt_detected = 1'b0;
    if (h) m_halted = 1'b1;
    dump_handshake(ndrop, delay);
  endtask

  initial begin
    dif.rx_done = 1'b0; dif.rx_data = 8'h00;
    dif.halt_detected = 1'b0; dif.dump_done = 1'b0;
    rst = 1'b1;
    m_halted = 1'b0; m_err = 1'b0; m_step = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    prog = '{32'h1234_5678, 32'hABCD_EF01, 32'h0000_0000};
    do_load();
    check_status("load");

    do_run(10, 2, 7);
    check_status("run");
    do_run(5, 0, 3);
    check_status("run while halted");

    prog = '{32'h1111_1111, 32'h0000_0000};
    do_load();
    for (int i = 0; i < 3; i++) do_step(1'b0, 0, 5);
    check_status("steps");

    prog = '{32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004};
    do_load();
    check_status("overflow");

    prog = '{32'h0000_0000};
    do_load();
    send_byte(8'h7A);
    m_err = 1'b1;
    check_status("bad command");

    send_byte(C_L);
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    check_reset_outputs("reset mid-load");
    rst = 1'b0;
    m_halted = 1'b0; m_err = 1'b0; m_step = 1'b0;
    prog = '{32'h0000_0005, 32'h0000_0000};
    do_load();
    check_status("reload");

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          prog.delete();
          for (int i = 0; i < int'(DEPTH); i++) begin
            logic [31:0] w;
            w = ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom | 32'h1);
            prog.push_back(w);
            if (w == 32'h0) break;
          end
          do_load();
        end
        1: begin
          int nd;
          nd = $urandom_range(0, 2);
          do_run($urandom_range(1, 15), nd, 2 * nd + 1 + $urandom_range(0, 4));
        end
        2: do_step($urandom_range(0, 3) == 0, 0, $urandom_range(1, 6));
        default: begin
          logic [7:0] b;
          do b = 8'($urandom); while (b == C_L || b == C_R || b == C_S);
          send_byte(b);
          m_err = 1'b1;
        end
      endcase
      check_status("random");
    end

    repeat (3) tick();
    check("pending writes", 32'(wr_q.size()), 32'(0));
    check("pending dumps",  32'(dump_q.size()), 32'(0));
    check("pending bursts", 32'(burst_len_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_run_controller.md
Name: debug_run_controller

Overview:
- Sequences the MIPS pipeline under host control over the UART receive path.
- Decodes single-byte commands and assembles received bytes into 32-bit words written sequentially into instruction memory.
- Gates pipeline advance in either continuous or single-step mode.
- After every halt or step, hands the UART transmit path to the dump sequencer through a start/done handshake.

Parameters:
- IMEM_DEPTH, 256, number of instruction-memory words; the load address range is 0..IMEM_DEPTH-1.
- HALT_WORD, 32'h00000000, instruction word that terminates a program load.
- CMD_LOAD, 8'h4C, command byte 'L'.
- CMD_RUN, 8'h52, command byte 'R'.
- CMD_STEP, 8'h53, command byte 'S'.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high; the only clock is clk.
- rx_done  in  1  one-cycle pulse; rx_data is valid.
- rx_data  in  8  received byte.
- halt_detected  in  1  high while the halt instruction is in the WB stage.
- dump_done  in  1  one-cycle pulse from the dump sequencer; the dump is complete.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  32  instruction-memory write address.
- imem_wdata  out  32  instruction-memory write data.
- cpu_enable  out  1  pipeline advance; the PC and latches update only when this is 1.
- cpu_rst  out  1  one-cycle pipeline soft reset.
- dump_start  out  1  one-cycle request to start a dump.
- step_mode  out  1  1 when the last run command was 'S'.
- halted  out  1  sticky flag; the program has reached halt.
- busy  out  1  1 in any state except IDLE.
- err  out  1  sticky error flag.

Behaviour:
- Reset values: every output is 0; imem_addr=0; the byte counter is 0; the assembly register is 0; state=IDLE.
- States: IDLE, LOAD_BYTE, LOAD_WRITE, RUN, STEP, DUMP_REQ, DUMP_WAIT.
- IDLE, on rx_done:
  - rx_data==CMD_LOAD: go to LOAD_BYTE; clear imem_addr, the byte counter, halted and err.
  - rx_data==CMD_RUN and halted==0: go to RUN; step_mode=0.
  - rx_data==CMD_STEP and halted==0: go to STEP; step_mode=1.
  - R or S while halted==1: ignored; err=1.
  - Any other byte: ignored; err=1.
  - err clears only on CMD_LOAD or rst.
- LOAD_BYTE:
  - Each rx_done shifts rx_data into the assembly register, MSB first: word = {word[23:0], rx_data}.
  - The 4th byte moves the FSM to LOAD_WRITE.
- LOAD_WRITE (one cycle):
  - imem_we=1, imem_wdata=the assembled word, imem_addr=the current address.
  - If the word==HALT_WORD: go to IDLE and pulse cpu_rst in the same cycle.
  - Else if imem_addr==IMEM_DEPTH-1: go to IDLE, pulse cpu_rst, set err=1 (overflow, no halt seen).
  - Else: imem_addr+1, go back to LOAD_BYTE.
  - The address never wraps.
- RUN:
  - cpu_enable=1 every cycle.
  - When halt_detected is sampled 1: next cycle cpu_enable=0, halted=1, go to DUMP_REQ.
- STEP:
  - cpu_enable=1 for exactly one cycle, then go to DUMP_REQ.
  - If halt_detected==1 during that cycle, set halted=1.
- DUMP_REQ: dump_start=1 for one cycle, cpu_enable=0; go to DUMP_WAIT.
- DUMP_WAIT:
  - Waits for dump_done, then goes to IDLE.
  - No timeout.
  - A dump_done seen in any other state is ignored.
- Bytes arriving in RUN, STEP, DUMP_REQ or DUMP_WAIT are dropped without error; they belong to the dump traffic window.
- Latency:
  - Command byte to first cpu_enable: 1 cycle.
  - Halt sample to dump_start: 2 cycles.
  - 4th byte to imem_we: 1 cycle.
- rst asserted in any state: next cycle is IDLE with all outputs 0, and any partially assembled word is discarded.
- imem_we, cpu_enable and dump_start are never high in the same cycle.

Test Plan:
- Load: rst; L, 12 34 56 78, AB CD EF 01, 00 00 00 00 → imem_we pulses at addr 0/1/2 with data 12345678/ABCDEF01/00000000; cpu_rst pulses with the 3rd write; busy=0 afterwards; err=0.
- Run to halt: after the load, send R; drive halt_detected=1 at cycle 10 of RUN → cpu_enable high for 10 cycles then 0; dump_start one cycle, 2 cycles after the halt sample; halted=1; after dump_done, busy=0; a following R sets err=1 and cpu_enable stays 0.
- Step: send S three times, each followed by dump_done 5 cycles after its dump_start → exactly three single-cycle cpu_enable pulses, three dump_start pulses, step_mode=1.
- Overflow: IMEM_DEPTH=4; L plus 16 non-halt bytes → writes at addr 0..3, then IDLE, err=1, cpu_rst pulses once.
- Bad command and dropped bytes: 0x7A in IDLE → err=1, no other output changes; bytes sent during DUMP_WAIT → no write, no state change.
- Reset mid-load: L, 2 bytes, rst, then L plus 4 bytes 00000005 → the single write has data 00000005 at addr 0.
